sample_bus_arbiter: RTL
=======================

// Module: sample_bus_arbiter
// PURPOSE
//  Shares one WIDTH-bit audio sample bus between 4 requesting effect units
//  (e.g. distortion, delay, tremolo, bypass tap) feeding the single output stage.
//  Round-robin arbitration with a bounded burst length guarantees no unit starves.
//  Drives the select of the 4:1 sample mux and registers the muxed sample plus valid.
// PARAMETERS
//  WIDTH      16  sample width in bits
//  MAX_BURST  8   max consecutive samples one grantee may send before forced release (>=1)
// PORTS
//  Clk        in   1          system clock; all state changes on rising edge
//  Reset_n    in   1          asynchronous, active-low reset
//  req        in   4          req[i]=1: unit i has a sample on d_i this cycle
//  d0..d3     in   WIDTH each sample data from units 0..3
//  grant      out  4          one-hot current owner; 4'b0000 when no owner
//  sel        out  2          mux select = index of owner (held when no owner)
//  q          out  WIDTH      registered sample from owner
//  q_valid    out  1          q holds a sample accepted from owner this cycle
// BEHAVIOUR
//  Reset (Reset_n=0, async): state=IDLE, grant=0, sel=0, q=0, q_valid=0,
//   burst count=0, priority pointer ptr=0.
//  FSM states: IDLE, BUSY, GAP.
//  IDLE: if req!=0, pick first i with req[i]=1 searching ptr, ptr+1, ... (mod 4).
//   Next edge: grant[i]=1, sel=i, count=0, ->BUSY. req=0: stay, q_valid=0.
//  BUSY: each edge with req[sel]=1: q<=d[sel], q_valid<=1, count<=count+1.
//   Release when req[sel]=0 (q_valid<=0 that edge) OR count reaches MAX_BURST
//   (the MAX_BURST-th sample is captured, then release). On release: grant<=0,
//   ptr<=sel+1 (2-bit wrap 3->0), ->GAP.
//  GAP: exactly one cycle, grant=0, q_valid=0, q holds last value; ->IDLE.
//  Latency: req[i] rising at edge t (arbiter idle) -> grant[i] after edge t+1;
//   first q_valid after edge t+2. Min idle between owners: 2 cycles (GAP+IDLE).
//  q_valid is never high while grant=0 except on the release edge's sample.
//   Precisely: q_valid high for the cycle after each captured sample only.
//  Requests from non-owners in BUSY are ignored (no capture, no preemption).
//  Simultaneous: owner drops req on the same edge count would hit MAX_BURST ->
//   single release, ptr=sel+1. All 4 req high continuously -> grants rotate
//   0,1,2,3,0 with MAX_BURST samples each.
//  count width = $clog2(MAX_BURST+1); compare count==MAX_BURST-1 with req
//   high to release; no overflow possible.
//  Reset asserted mid-burst: all outputs to reset values immediately
//   (async); after deassertion behaves as from power-up, ptr=0.
//  grant is always 0 or one-hot; sel changes only on IDLE->BUSY.
// STRUCTURE
//  Shared package pedal_pkg: typedef enum logic [1:0] {IDLE,BUSY,GAP} arb_state_t;
//   localparam int N_SRC = 4.
//  Sub-module: instantiate mux4_1 #(.width(WIDTH)) for data path, s=sel;
//   q register, FSM, ptr, counter and round-robin pick stay in this module.
// TESTING
//  1 Reset: Reset_n=0 mid-burst -> grant=0, q_valid=0, q=0 same cycle, no clock.
//  2 Single req[2]=1 from idle, d2=16'h1234 -> grant=4'b0100 after 1 edge,
//    q=16'h1234 q_valid=1 after 2 edges; 8 samples then 1 GAP, re-grant to 2.
//  3 req=4'b1111 held, MAX_BURST=8 -> grants 0,1,2,3,0 each 8 q_valid cycles,
//    q_valid low exactly 2 cycles between owners.
//  4 Owner 1 drops req after 3 samples -> 3 q_valid pulses, release, ptr=2;
//    pending req[0] and req[3] -> next grant 3, then 0.
//  5 req[3] and req[0] both rise in IDLE with ptr=3 -> grant 3; wrap ptr->0
//    -> grant 0 next.
//  6 Non-owner req toggling during BUSY -> no change to grant, sel, q source.

Source files
------------

// File: rtl/pedal_pkg.sv
// Shared types and helpers for the effect-unit sample bus arbiter.
//  arb_state_t : arbiter FSM states
//  N_SRC       : number of requesting effect units
//  PTR_W       : width of a source index / priority pointer
//  rr_pick     : round-robin search starting at the priority pointer
package pedal_pkg;

    localparam int N_SRC = 4;
    localparam int unsigned PTR_W = $clog2(N_SRC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    // First requester found searching ptr, ptr+1, ... with index wrap.
    // Returns ptr when nothing is requesting; callers gate on |req.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                                 input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] idx;
        rr_pick = ptr;
        // Walk the search order backwards so the nearest hit to ptr wins last.
        for (int k = N_SRC - 1; k >= 0; k--) begin
            idx = ptr + PTR_W'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/sample_bus_arbiter_if.sv
// Sample bus between the effect units and the output-stage arbiter.
//  req      : per-unit sample-present flags
//  d0..d3   : per-unit sample data
//  grant    : one-hot current owner (0 when unowned)
//  sel      : mux select / owner index
//  q        : registered sample from the owner
//  q_valid  : q was captured from the owner on the last edge
// master = effect-unit side, slave = arbiter side.
interface sample_bus_arbiter_if #(
    parameter int unsigned WIDTH = 16
);
    import pedal_pkg::*;

    logic [N_SRC-1:0] req;
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [N_SRC-1:0] grant;
    logic [PTR_W-1:0] sel;
    logic [WIDTH-1:0] q;
    logic             q_valid;

    modport master (
        output req, d0, d1, d2, d3,
        input  grant, sel, q, q_valid
    );

    modport slave (
        input  req, d0, d1, d2, d3,
        output grant, sel, q, q_valid
    );

endinterface

// File: rtl/sample_bus_arbiter_mux4.sv
// 4:1 sample mux feeding the arbiter's output register.
//  s        : select index
//  d0..d3   : candidate samples
//  y_c      : selected sample (combinational)
module mux4_1 #(
    parameter int unsigned width = 16
) (
    input  logic [1:0]       s,
    input  logic [width-1:0] d0,
    input  logic [width-1:0] d1,
    input  logic [width-1:0] d2,
    input  logic [width-1:0] d3,
    output logic [width-1:0] y_c
);

    always_comb begin
        y_c = d0;
        unique case (s)
            2'd0: y_c = d0;
            2'd1: y_c = d1;
            2'd2: y_c = d2;
            2'd3: y_c = d3;
            default: y_c = d0;
        endcase
    end

endmodule

// File: rtl/sample_bus_arbiter.sv
// Round-robin arbiter sharing one audio sample bus between four effect units.
// An owner keeps the bus while it requests, for at most MAX_BURST samples,
// then the bus sits idle for one GAP cycle before the next arbitration.
//  Clk      : system clock, rising edge
//  Reset_n  : asynchronous active-low reset
//  bus      : sample_bus_arbiter_if slave (req, d0..d3 in; grant, sel, q, q_valid out)
module sample_bus_arbiter #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    sample_bus_arbiter_if.slave  bus
);
    import pedal_pkg::*;

    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state_q, state_d;
    logic [N_SRC-1:0] grant_q, grant_d;
    logic [PTR_W-1:0] sel_q,   sel_d;
    logic [PTR_W-1:0] ptr_q,   ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             q_valid_q, q_valid_d;

    logic [WIDTH-1:0] mux_c;
    logic [PTR_W-1:0] pick_c;
    logic             release_c;

    // Data path: owner's sample selected by the held mux select.
    mux4_1 #(.width(WIDTH)) u_mux (
        .s   (sel_q),
        .d0  (bus.d0),
        .d1  (bus.d1),
        .d2  (bus.d2),
        .d3  (bus.d3),
        .y_c (mux_c)
    );

    assign pick_c = rr_pick(bus.req, ptr_q);

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            count_q   <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        q_d       = q_q;
        q_valid_d = 1'b0;
        release_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_d = N_SRC'(1) << pick_c;
                    sel_d   = pick_c;
                    count_d = '0;
                    state_d = BUSY;
                end
            end

            BUSY: begin
                if (bus.req[sel_q]) begin
                    q_d       = mux_c;
                    q_valid_d = 1'b1;
                    count_d   = count_q + CNT_W'(1);
                    // The MAX_BURST-th sample is still captured on the release edge.
                    if (count_q == CNT_W'(MAX_BURST - 1)) begin
                        release_c = 1'b1;
                    end
                end else begin
                    release_c = 1'b1;
                end

                if (release_c) begin
                    grant_d = '0;
                    ptr_d   = sel_q + PTR_W'(1);
                    state_d = GAP;
                end
            end

            GAP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign bus.grant   = grant_q;
    assign bus.sel     = sel_q;
    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;

endmodule
